spi_master_sched: RTL
=====================

# spi_master_sched

Round-robin SPI master scheduler that shares one 8-bit SPI link between NREQ on-chip requesters. It arbitrates pending requests, generates ss_n/sck/mosi in SPI mode 0 (sck idle low, data sampled on rising edge, MSB first), captures miso, and returns the received byte with a one-cycle completion pulse. It drives the SPI slave receivers on the same bus and is the only master of the link.

## Interface
- NREQ, 4: number of requesters (2..8).
- CLK_DIV, 4: sck half-period in clk cycles (>=1).
- GAP, 2: minimum clk cycles spent in GAP state (ss_n high) after each transfer (>=0).

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester transfer request, level.
- tx_data  in  8*NREQ  byte for requester i at [8i+7:8i]; sampled at grant.
- gnt  out  NREQ  one-hot grant, held for the whole transfer.
- done  out  1  one-cycle pulse, transfer complete; rx_data valid.
- rx_data  out  8  last received byte; holds until next done.
- busy  out  1  high whenever state != IDLE.
- ss_n  out  1  slave select, active-low.
- sck  out  1  serial clock.
- mosi  out  1  serial data to slave.
- miso  in  1  serial data from slave (pre-synchronised).

## Operation
- States: IDLE, SETUP, XFER, HOLD, GAP.
- Reset values: gnt=0, done=0, rx_data=0, busy=0, ss_n=1, sck=0, mosi=0, rr pointer=0, state IDLE.
- IDLE: if any req bit set, select first set bit searching ptr, ptr+1, ... mod NREQ; load tx_data slice into tx shift register; next cycle gnt[i]=1, ss_n=0, mosi=tx[7], state SETUP; ptr <= (i+1) mod NREQ.
- SETUP: CLK_DIV cycles, sck low.
- XFER: 16 sck half-periods of CLK_DIV cycles each, starting with sck rising. On each rising edge master samples miso into rx shift register (LSB in, shift left). On each falling edge except the 8th, mosi advances to next lower tx bit. After 8th falling edge sck stays low, state HOLD.
- HOLD: CLK_DIV cycles, ss_n low, sck low.
- End of HOLD: ss_n=1, gnt=0, done=1 for one cycle, rx_data <= rx shift register, mosi=0, state GAP.
- GAP: GAP cycles, then IDLE. With GAP=0, IDLE is entered directly.
- req deasserted after grant: ignored, transfer completes and done pulses. A req still high after done competes normally; the pointer guarantees every pending requester is served within NREQ transfers.
- tx_data changes after the grant cycle have no effect.

## Timing
- Arbitration: req seen in IDLE at cycle t -> gnt/ss_n low/mosi valid at t+1.
- ss_n low for exactly 18*CLK_DIV cycles (SETUP + 16 half-periods + HOLD).
- First sck rise at t+1+CLK_DIV; sck rises every 2*CLK_DIV cycles.
- done coincides with first ss_n-high cycle; rx_data updates same edge.
- ss_n high between back-to-back transfers for GAP+1 cycles minimum (GAP state + IDLE arbitration cycle).
- Grant-to-grant period for continuous requests: 18*CLK_DIV + GAP + 1 cycles.
- rst_n assertion mid-transfer: outputs take reset values asynchronously (ss_n=1, sck=0, gnt=0); no done pulse; ptr returns to 0.

## Test plan
- Single req[0], tx 0xA5, slave model drives miso 0x3C MSB-first on falling edges -> mosi at rising edges 1,0,1,0,0,1,0,1; ss_n low 72 cycles (CLK_DIV=4); done pulse once; rx_data=0x3C; gnt=0001 during transfer.
- req=1111 held from reset release, distinct tx bytes -> grants in order 0,1,2,3,0; each grant 18*CLK_DIV+GAP+1=75 cycles after previous; ss_n high exactly 3 cycles between frames.
- req[2] alone, then req[1] and req[3] raised together during that transfer -> next grant 3, then 1.
- req[1] dropped the cycle after gnt -> full 8-bit frame still produced, done pulses, gnt clears with ss_n rising.
- rst_n asserted after 4th sck rise -> ss_n=1, sck=0, gnt=0 immediately, no done, rx_data=0; after release req=1111 grants 0 first.
- CLK_DIV=1, GAP=0, tx 0xFF, miso 0x00 -> sck toggles every clk, ss_n low 18 cycles, rx_data=0x00, next grant 19 cycles after previous.

Source files
------------

// File: rtl/spi_master_sched_if.sv
// spi_master_sched_if: requester handshake plus the SPI pins of the shared link.
interface spi_master_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] tx_data;
  logic [NREQ-1:0]   gnt;
  logic              done;
  logic [7:0]        rx_data;
  logic              busy;
  logic              ss_n;
  logic              sck;
  logic              mosi;
  logic              miso;
  modport master (
    input  req, tx_data, miso,
    output gnt, done, rx_data, busy, ss_n, sck, mosi
  );
  modport slave (
    output req, tx_data, miso,
    input  gnt, done, rx_data, busy, ss_n, sck, mosi
  );
endinterface

// File: rtl/spi_master_sched.sv
// spi_master_sched: round-robin scheduler sharing one mode-0 8-bit SPI link between NREQ requesters.
module spi_master_sched #(
  parameter int NREQ    = 4,
  parameter int CLK_DIV = 4,
  parameter int GAP     = 2
) (
  input logic                clk,
  input logic                rst_n,
  spi_master_sched_if.master bus_io
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(CLK_DIV + GAP + 1);
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      half_q, half_d;
  logic [PW-1:0]   ptr_q, ptr_d, sel, idx;
  logic            found;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [6:0]      tx_q, tx_d;
  logic [7:0]      rx_q, rx_d, rx_data_q, rx_data_d, slice;
  logic            done_q, done_d, ss_n_q, ss_n_d, sck_q, sck_d, mosi_q, mosi_d;
  logic            last, gap_end;
  assign last    = cnt_q == CW'(CLK_DIV - 1);
  assign gap_end = cnt_q == CW'(GAP - 1);
  assign slice   = bus_io.tx_data[{sel, 3'b000} +: 8];
  // first pending requester at or after the round-robin pointer
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus_io.req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
      idx = (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      half_q    <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
      ss_n_q    <= ss_n_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    half_d  = half_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (found) state_d = S_SETUP;
      end
      S_SETUP: if (last) begin
        cnt_d   = '0;
        state_d = S_XFER;
      end
      S_XFER: if (last) begin
        cnt_d  = '0;
        half_d = half_q + 1'b1;
        if (half_q == 4'd15) state_d = S_HOLD;
      end
      S_HOLD: if (last) begin
        cnt_d   = '0;
        state_d = (GAP == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: if (gap_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // half-periods alternate high/low; half 15 is the trailing low phase with no mosi advance
  always_comb begin
    gnt_d     = gnt_q;
    ss_n_d    = ss_n_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;
    if (state_q == S_IDLE && found) begin
      gnt_d  = NREQ'(1) << sel;
      ss_n_d = 1'b0;
      mosi_d = slice[7];
      tx_d   = slice[6:0];
      ptr_d  = (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
    end
    if ((state_q == S_SETUP && last) || (state_q == S_XFER && last && !sck_q && half_q != 4'd15)) begin
      sck_d = 1'b1;
      rx_d  = {rx_q[6:0], bus_io.miso};
    end
    if (state_q == S_XFER && last && sck_q) begin
      sck_d  = 1'b0;
      mosi_d = (half_q != 4'd14) ? tx_q[6] : mosi_q;
      tx_d   = (half_q != 4'd14) ? {tx_q[5:0], 1'b0} : tx_q;
    end
    if (state_q == S_HOLD && last) begin
      ss_n_d    = 1'b1;
      gnt_d     = '0;
      done_d    = 1'b1;
      rx_data_d = rx_q;
      mosi_d    = 1'b0;
    end
  end
  assign bus_io.gnt     = gnt_q;
  assign bus_io.done    = done_q;
  assign bus_io.rx_data = rx_data_q;
  assign bus_io.busy    = state_q != S_IDLE;
  assign bus_io.ss_n    = ss_n_q;
  assign bus_io.sck     = sck_q;
  assign bus_io.mosi    = mosi_q;
endmodule
